// File: rtl/split_tracked.sv
// Registered one-master to N_SLAVES address splitter that tracks a single outstanding transaction.
// Optional slave timeout is enabled by defining SPLIT_TRACKED_TIMEOUT_EN.
module split_tracked #(
  parameter int N_SLAVES = 2,
  parameter int P_SLAVES = 31,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
  parameter int TIMEOUT_W = 10,
  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1,
  localparam int STRB_W = DATA_W / 8,
  localparam int REQ_W = 1 + ADDR_W + DATA_W + STRB_W,
  localparam int RESP_W = DATA_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQ_W-1:0]             m_req,
  output logic [RESP_W-1:0]            m_resp,
  output logic [N_SLAVES*REQ_W-1:0]    s_req,
  input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
  output logic                         err,
  output logic                         busy
);

  if (N_SLAVES < 1 || N_SLAVES > 16 || DATA_W % 8 != 0 || TIMEOUT_W < 1) begin : g_bad_cfg
    $error("split_tracked: unsupported parameter set");
  end

  // Valid/ready: the master holds valid and its fields stable until it sees ready for one
  // cycle; each slave sees valid from the cycle after acceptance until the edge after its ready.
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_SLAVES);

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [SEL_W-1:0]   sel_q;
  logic               m_valid;
  logic               mapped;
  logic               pick_ready;
  logic [DATA_W-1:0]  pick_rdata;

  assign m_valid = m_req[REQ_W-1];

  if (N_SLAVES == 1) begin : g_one
    assign sel    = '0;
    assign mapped = 1'b1;
  end else begin : g_many
    assign sel    = m_req[DATA_W + STRB_W + P_SLAVES -: SEL_W];
    assign mapped = {1'b0, sel} < N_LIM;
  end

  // Only the latched slave's response can complete the transaction.
  always_comb begin
    pick_ready = 1'b0;
    pick_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (SEL_W'(i) == sel_q) begin
        pick_ready = s_resp[i*RESP_W];
        pick_rdata = s_resp[i*RESP_W + 1 +: DATA_W];
      end
    end
  end

`ifdef SPLIT_TRACKED_TIMEOUT_EN
  // Leaving REQ on the edge where the count would reach all-ones gives 2^TIMEOUT_W-1 REQ cycles.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);
  logic [TIMEOUT_W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      m_resp <= '0;
      s_req  <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      sel_q  <= '0;
`ifdef SPLIT_TRACKED_TIMEOUT_EN
      cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m_valid) begin
            busy <= 1'b1;
            if (mapped) begin
              sel_q <= sel;
              state <= REQ;
              for (int i = 0; i < N_SLAVES; i++) begin
                if (SEL_W'(i) == sel) s_req[i*REQ_W +: REQ_W] <= m_req;
              end
`ifdef SPLIT_TRACKED_TIMEOUT_EN
              cnt <= '0;
`endif
            end else begin
              state  <= ERR;
              m_resp <= {ERR_DATA, 1'b1};
              err    <= 1'b1;
            end
          end
        end
        REQ: begin
          if (pick_ready) begin
            s_req  <= '0;
            m_resp <= {pick_rdata, 1'b1};
            state  <= RESP;
          end
`ifdef SPLIT_TRACKED_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            s_req  <= '0;
            m_resp <= {ERR_DATA, 1'b1};
            err    <= 1'b1;
            state  <= ERR;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
`endif
        end
        RESP, ERR: begin
          m_resp <= '0;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
